// File: rtl/adpll_pkg.sv
// Shared types and constants for the ADPLL programming-port master.
package adpll_pkg;

  localparam int PARAM_W  = 5;
  localparam int SEL_W    = 3;
  localparam int NPARAM   = 8;
  localparam int HOLD_DEF = 4;
  localparam int GAP_DEF  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_CLRGAP,
    S_SETUP,
    S_STROBE,
    S_HOLDGAP,
    S_DONE
  } pgm_state_t;

  // Index of the lowest set bit. Returns 0 for an empty mask, but callers
  // check for that case first.
  function automatic logic [SEL_W-1:0] lowest_set(input logic [NPARAM-1:0] m);
    lowest_set = '0;
    for (int i = NPARAM - 1; i >= 0; i--)
      if (m[i]) lowest_set = SEL_W'(i);
  endfunction

endpackage

// File: rtl/adpll_pgm_shadow.sv
// 8x5 shadow register file for the ADPLL loop parameters.
// The sequencer read port writes through: a write in the same cycle is
// visible immediately.
// The optional registered readback port is enabled by ADPLL_PGM_READBACK_EN.
module adpll_pgm_shadow
  import adpll_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [SEL_W-1:0]   waddr,
  input  logic [PARAM_W-1:0] wdata,
  input  logic [SEL_W-1:0]   raddr,
`ifdef ADPLL_PGM_READBACK_EN
  input  logic [SEL_W-1:0]   rb_addr,
  output logic [PARAM_W-1:0] rb_data,
`endif
  output logic [PARAM_W-1:0] rdata
);

  logic [NPARAM-1:0][PARAM_W-1:0] mem;

  // Table storage, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  // A write and a start can share a cycle, so bypass the pending write.
  assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

`ifdef ADPLL_PGM_READBACK_EN
  // Registered host readback with one cycle of latency. It is usable at any time.
  always_ff @(posedge clk) begin
    if (rst) rb_data <= '0;
    else     rb_data <= mem[rb_addr];
  end
`endif

endmodule

// File: rtl/adpll_pgm_master.sv
// Programming-port master. It replays selected shadow entries onto the
// ADPLL clr/pgm/param_sel/pgm_value port. Each write has guaranteed setup,
// HOLD-cycle strobe width and GAP-cycle hold time.
// Optional readback port: ADPLL_PGM_READBACK_EN.
module adpll_pgm_master
  import adpll_pkg::*;
#(
  parameter int HOLD = HOLD_DEF,
  parameter int GAP  = GAP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_addr,
  input  logic [PARAM_W-1:0] wr_data,
  input  logic               start,
  input  logic               clr_first,
  input  logic [NPARAM-1:0]  mask,
`ifdef ADPLL_PGM_READBACK_EN
  input  logic [SEL_W-1:0]   rd_addr,
  output logic [PARAM_W-1:0] rd_data,
`endif
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               clr,
  output logic               pgm,
  output logic [SEL_W-1:0]   param_sel,
  output logic [PARAM_W-1:0] pgm_value
);

  localparam logic [3:0] HOLD_CNT = 4'(HOLD - 1);
  localparam logic [3:0] GAP_CNT  = 4'(GAP - 1);

  pgm_state_t          st, st_n;
  logic [3:0]          cnt, cnt_n;
  logic [SEL_W-1:0]    idx, idx_n;
  logic [NPARAM-1:0]   mask_q, mask_n;
  logic                adv, sh_we, busy_st;
  logic [PARAM_W-1:0]  rd_val;

  logic                busy_n, done_n, err_n, clr_n, pgm_n;
  logic [SEL_W-1:0]    param_sel_n;
  logic [PARAM_W-1:0]  pgm_value_n;

  adpll_pgm_shadow u_shadow (
    .clk     (clk),
    .rst     (rst),
    .we      (sh_we),
    .waddr   (wr_addr),
    .wdata   (wr_data),
    .raddr   (idx_n),
`ifdef ADPLL_PGM_READBACK_EN
    .rb_addr (rd_addr),
    .rb_data (rd_data),
`endif
    .rdata   (rd_val)
  );

  // DONE already shows busy low, so DONE accepts host traffic as IDLE does.
  assign busy_st = (st != S_IDLE) && (st != S_DONE);

  // Next-state logic plus the next values of the registered outputs.
  always_comb begin
    st_n   = st;
    cnt_n  = cnt;
    idx_n  = idx;
    mask_n = mask_q;
    adv    = 1'b0;
    sh_we  = 1'b0;
    case (st)
      S_IDLE, S_DONE: begin
        sh_we = wr_en;
        st_n  = S_IDLE;
        if (start) begin
          mask_n = mask;
          if (clr_first) begin
            st_n  = S_CLEAR;
            cnt_n = HOLD_CNT;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (cnt == '0) begin
          st_n  = S_CLRGAP;
          cnt_n = GAP_CNT;
        end else cnt_n = cnt - 4'd1;
      end
      S_CLRGAP: begin
        if (cnt == '0) adv = 1'b1;
        else           cnt_n = cnt - 4'd1;
      end
      S_SETUP: begin
        st_n  = S_STROBE;
        cnt_n = HOLD_CNT;
      end
      S_STROBE: begin
        if (cnt == '0) begin
          st_n  = S_HOLDGAP;
          cnt_n = GAP_CNT;
        end else cnt_n = cnt - 4'd1;
      end
      S_HOLDGAP: begin
        if (cnt == '0) adv = 1'b1;
        else           cnt_n = cnt - 4'd1;
      end
      default: st_n = S_IDLE;
    endcase

    // Visited bits are retired from the mask, so the index only ever moves
    // upward and cannot wrap past entry 7.
    if (adv) begin
      if (mask_n != '0) begin
        st_n         = S_SETUP;
        idx_n        = lowest_set(mask_n);
        mask_n[idx_n] = 1'b0;
      end else begin
        st_n = S_DONE;
      end
    end

    busy_n      = (st_n != S_IDLE) && (st_n != S_DONE);
    done_n      = (st_n == S_DONE);
    clr_n       = (st_n == S_CLEAR);
    pgm_n       = (st_n == S_STROBE);
    err_n       = busy_st && (start || wr_en);
    param_sel_n = '0;
    pgm_value_n = '0;
    if (st_n == S_SETUP) begin
      param_sel_n = idx_n;
      pgm_value_n = rd_val;
    end else if ((st_n == S_STROBE) || (st_n == S_HOLDGAP)) begin
      param_sel_n = param_sel;
      pgm_value_n = pgm_value;
    end
  end

  // State, counters and registered port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      mask_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      clr       <= 1'b0;
      pgm       <= 1'b0;
      param_sel <= '0;
      pgm_value <= '0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      mask_q    <= mask_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      clr       <= clr_n;
      pgm       <= pgm_n;
      param_sel <= param_sel_n;
      pgm_value <= pgm_value_n;
    end
  end

endmodule

// File: tb/tb_adpll_pgm_master.sv
// Scoreboard bench for adpll_pgm_master (default HOLD=4, GAP=2).
// Cycle 1 is the first cycle after the edge that samples start.
module tb_adpll_pgm_master;
  import adpll_pkg::*;

  localparam int H = HOLD_DEF;
  localparam int G = GAP_DEF;

  logic       clk = 1'b0, rst = 1'b1;
  logic       wr_en = 1'b0, start = 1'b0, clr_first = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [7:0] mask = '0;
  logic       busy, done, err, clr, pgm;
  logic [2:0] param_sel;
  logic [4:0] pgm_value;
`ifdef ADPLL_PGM_READBACK_EN
  logic [2:0] rd_addr = '0;
  logic [4:0] rd_data;
`endif

  int errors = 0;
  int checks = 0;
  logic [4:0] model [8];

  typedef struct {
    logic [2:0] sel;
    logic [4:0] val;
    int         rise;
  } rec_t;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  adpll_pgm_master dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .clr_first (clr_first),
    .mask      (mask),
`ifdef ADPLL_PGM_READBACK_EN
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
`endif
    .busy      (busy),
    .done      (done),
    .err       (err),
    .clr       (clr),
    .pgm       (pgm),
    .param_sel (param_sel),
    .pgm_value (pgm_value)
  );

  task automatic wr(input logic [2:0] a, input logic [4:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // Issue one start and score the whole sequence against the model.
  // co_wr applies a shadow write in the start cycle.
  // inj_at > 0 pulses start and wr_en together in that cycle while busy.
  task automatic run_seq(input string name, input bit cf, input logic [7:0] m,
                         input bit co_wr, input logic [2:0] wa, input logic [4:0] wd,
                         input int inj_at);
    int   k, c, exp_done, cyc, clr_cnt, pgm_cnt, gap_left;
    bit   pgm_p, fin, stable_bad, overlap;
    logic [2:0] hs;
    logic [4:0] hv;
    rec_t r;
    k = 0; clr_cnt = 0; pgm_cnt = 0; gap_left = 0;
    pgm_p = 1'b0; fin = 1'b0; stable_bad = 1'b0; overlap = 1'b0;
    hs = '0; hv = '0;
    @(negedge clk);
    if (co_wr) begin
      wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      model[wa] = wd;
    end
    c = cf ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        r.sel  = 3'(i);
        r.val  = model[i];
        r.rise = 2 + c * (H + G) + k * (1 + H + G);
        exp_q.push_back(r);
        k++;
      end
    end
    exp_done = 1 + c * (H + G) + k * (1 + H + G);
    start = 1'b1; clr_first = cf; mask = m;
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0; clr_first = 1'b0; mask = '0;
    cyc = 1;
    while (!fin && cyc <= exp_done + 10) begin
      if (clr && pgm) overlap = 1'b1;
      if (cyc == 1) begin
        checks++;
        if (busy !== (exp_done > 1)) begin
          errors++;
          $display("FAIL %s busy@1: got %b want %b", name, busy, (exp_done > 1));
        end
      end
      if (inj_at > 0 && cyc == inj_at + 1) begin
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL %s err pulse: got %b want 1", name, err); end
      end
      if (inj_at > 0 && cyc == inj_at + 2) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL %s err single: got %b want 0", name, err); end
      end
      if (clr) clr_cnt++;
      if (gap_left > 0) begin
        if (param_sel !== hs || pgm_value !== hv) stable_bad = 1'b1;
        gap_left--;
      end
      if (!pgm && pgm_p) begin
        gap_left = G - 1;
        if (param_sel !== hs || pgm_value !== hv) stable_bad = 1'b1;
      end
      if (pgm && !pgm_p) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s strobe: unexpected pgm rise at cycle %0d", name, cyc);
        end else begin
          r = exp_q.pop_front();
          if (param_sel !== r.sel || pgm_value !== r.val || cyc != r.rise) begin
            errors++;
            $display("FAIL %s strobe: got sel=%0d val=%h cyc=%0d want sel=%0d val=%h cyc=%0d",
                     name, param_sel, pgm_value, cyc, r.sel, r.val, r.rise);
          end
        end
        hs = param_sel; hv = pgm_value;
      end
      if (pgm) begin
        pgm_cnt++;
        if (param_sel !== hs || pgm_value !== hv) stable_bad = 1'b1;
      end
      if (done) begin
        fin = 1'b1;
        checks++;
        if (cyc != exp_done || busy !== 1'b0 || param_sel !== 3'd0 || pgm_value !== 5'd0) begin
          errors++;
          $display("FAIL %s done: got cyc=%0d busy=%b sel=%0d val=%h want cyc=%0d busy=0 sel=0 val=0",
                   name, cyc, busy, param_sel, pgm_value, exp_done);
        end
      end
      pgm_p = pgm;
      if (inj_at > 0 && cyc == inj_at) begin
        start = 1'b1; mask = 8'hFF; wr_en = 1'b1; wr_addr = 3'd7; wr_data = 5'h03;
      end else begin
        start = 1'b0; mask = '0; wr_en = 1'b0;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0; wr_en = 1'b0;
    checks++;
    if (!fin) begin errors++; $display("FAIL %s timeout: no done within %0d cycles", name, exp_done + 10); end
    checks++;
    if (clr_cnt != c * H) begin errors++; $display("FAIL %s clr width: got %0d want %0d", name, clr_cnt, c * H); end
    checks++;
    if (pgm_cnt != k * H) begin errors++; $display("FAIL %s pgm width: got %0d want %0d", name, pgm_cnt, k * H); end
    checks++;
    if (stable_bad || overlap) begin
      errors++;
      $display("FAIL %s bus: got unstable=%b overlap=%b want 0/0", name, stable_bad, overlap);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s strobes missing: got %0d left want 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, clr, pgm, param_sel, pgm_value} !== 13'd0) begin
      errors++;
      $display("FAIL reset outputs: got %b want 0", {busy, done, err, clr, pgm, param_sel, pgm_value});
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  task automatic test_single;
    wr(3'd3, 5'h15);
    run_seq("single", 1'b0, 8'h08, 1'b0, 3'd0, 5'd0, 0);
  endtask

  // The wr_en to entry 7 injected mid-sequence must be dropped.
  task automatic test_clear_multi;
    wr(3'd0, 5'h0A);
    wr(3'd7, 5'h1C);
    run_seq("clear_multi", 1'b1, 8'h81, 1'b0, 3'd0, 5'd0, 5);
  endtask

  task automatic test_empty;
    run_seq("empty", 1'b0, 8'h00, 1'b0, 3'd0, 5'd0, 0);
  endtask

  task automatic test_write_collision;
    wr(3'd2, 5'h01);
    run_seq("wr_collide", 1'b0, 8'h04, 1'b1, 3'd2, 5'h1B, 0);
  endtask

  task automatic test_reset_mid;
    wr(3'd1, 5'h0A);
    @(negedge clk);
    start = 1'b1; mask = 8'h02;
    @(negedge clk);
    start = 1'b0; mask = '0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pgm !== 1'b1) begin errors++; $display("FAIL reset_mid pre: got pgm=%b want 1", pgm); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, err, clr, pgm, param_sel, pgm_value} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %b want 0", {busy, done, err, clr, pgm, param_sel, pgm_value});
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    run_seq("after_reset", 1'b0, 8'h02, 1'b0, 3'd0, 5'd0, 0);
  endtask

`ifdef ADPLL_PGM_READBACK_EN
  task automatic test_readback;
    int n;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 5'h1F; rd_addr = 3'd6;
    @(negedge clk);
    wr_en = 1'b0; model[6] = 5'h1F;
    @(negedge clk);
    checks++;
    if (rd_data !== 5'h1F) begin errors++; $display("FAIL readback idle: got %h want 1f", rd_data); end
    start = 1'b1; mask = 8'h40;
    @(negedge clk);
    start = 1'b0; mask = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rd_data !== 5'h1F) begin
      errors++;
      $display("FAIL readback busy: got busy=%b rd=%h want 1/1f", busy, rd_data);
    end
    n = 0;
    while (!done && n < 30) begin @(negedge clk); n++; end
    checks++;
    if (!done) begin errors++; $display("FAIL readback timeout: got no done want done"); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_clear_multi;
    test_empty;
    test_write_collision;
    test_reset_mid;
`ifdef ADPLL_PGM_READBACK_EN
    test_readback;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adpll_pgm_master.md
# adpll_pgm_master

Programming-port master for the ADPLL parameter bank. It keeps a host-writable shadow table of the eight 5-bit loop parameters. On a start request it replays the selected entries onto the ADPLL `clr`/`pgm`/`param_sel`/`pgm_value` programming port. Each write uses guaranteed setup, strobe-width and hold spacing. It sits between the host/test logic and `adpll_top`, driving the same port that `adpll_top` receives.

## Interface
Parameters:
- `HOLD`, default 4: cycles `pgm` (or `clr`) is held high per write; legal range is 1 to 15.
- `GAP`, default 2: cycles after strobe fall during which the bus is held stable with `pgm=0`; legal range is 1 to 15.

Ports:
- `clk`  in  1  sampling clock; the single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  shadow-table write strobe.
- `wr_addr`  in  3  shadow entry index; this equals the `param_sel` code.
- `wr_data`  in  5  shadow entry value.
- `start`  in  1  one-cycle request to begin a programming sequence.
- `clr_first`  in  1  sampled with `start`; when 1, a clear pulse is issued before the writes.
- `mask`  in  8  sampled with `start`; bit i=1 programs entry i.
- `busy`  out  1  high from the cycle after an accepted start until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse when `start` or `wr_en` arrives while `busy`.
- `clr`  out  1  ADPLL clear command.
- `pgm`  out  1  ADPLL program strobe.
- `param_sel`  out  3  ADPLL parameter select.
- `pgm_value`  out  5  ADPLL program value.

## Operation
- All outputs are registered. After `rst`, every output is 0 and every shadow entry is 0.
- **FSM states:** IDLE, CLEAR, CLRGAP, SETUP, STROBE, HOLDGAP, DONE.
- **IDLE:**
  - `wr_en` writes the shadow entry.
  - On `start`, the block latches `mask` and `clr_first`.
  - If both `wr_en` and `start` are high in the same cycle, the write lands first. The sequence uses the new value.
- **Start transition:**
  - If `clr_first` is 1, go to CLEAR.
  - Otherwise, if the mask is non-zero, go to SETUP on the lowest set bit.
  - Otherwise go to DONE.
- **CLEAR:** `clr=1` for HOLD cycles, then CLRGAP for GAP cycles with `clr=0`. Then go to SETUP, or to DONE if the mask is 0.
- **SETUP:** one cycle. `param_sel` is set to the index and `pgm_value` to the shadow entry; `pgm=0`.
- **STROBE:** `pgm=1` for HOLD cycles. `param_sel` and `pgm_value` stay stable.
- **HOLDGAP:** `pgm=0` for GAP cycles with the bus unchanged. Then go to SETUP for the next higher set mask bit, or to DONE.
- **DONE:** one cycle. `done=1` and `busy` drops in the same cycle. `param_sel` and `pgm_value` return to 0, then the FSM returns to IDLE.
- **While busy:**
  - `start` is ignored and pulses `err`.
  - `wr_en` is ignored (the shadow table is unchanged) and pulses `err`.
  - If both arrive in the same cycle, `err` pulses once.
- **Indexing:** mask bits are visited in ascending order. The mask index counter is 3 bits; it stops at index 7 and does not wrap.
- **Mid-sequence reset:** `rst` forces IDLE on the next edge and zeros all outputs and the shadow table. No partial strobe continues.

## Timing
- Cycle 0 is the edge where `start` is sampled. `busy` is 1 from cycle 1.
- With clear count c ∈ {0,1} and N set mask bits, `done` is high in cycle 1 + c·(HOLD+GAP) + N·(1+HOLD+GAP).
- For defaults and a single write: SETUP in cycle 1, `pgm` high in cycles 2–5, gap in cycles 6–7, `done` in cycle 8.
- The bus is stable at least 1 cycle before `pgm` rises and at least GAP cycles after it falls.
- `clr` and `pgm` are never high together.
- Shadow write-to-read latency is 0 cycles: a write in cycle k is used by a SETUP in cycle k+1 or later.

## Configuration
- Macro: `ADPLL_PGM_READBACK_EN`.
- **When defined:** the block adds input `rd_addr[2:0]` and output `rd_data[4:0]`. `rd_data` is a registered shadow read with 1-cycle latency, reset to 0. It is legal at any time, including while busy.
- **When undefined:** these ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `adpll_pkg` holds:
  - `PARAM_W=5`
  - `SEL_W=3`
  - `NPARAM=8`
  - the `pgm_state_t` enum for the seven FSM states
  - default HOLD and GAP constants
- Sub-module `adpll_pgm_shadow` is an 8×5 register file with a synchronous write port, one combinational read port for the sequencer, and an optional registered readback port. The FSM, HOLD/GAP countdown counter and mask index live in `adpll_pgm_master`.

## Test plan
- **Single write, no clear:** write entry 3=5'h15, then `start` with `mask`=8'h08, `clr_first`=0. Expect `param_sel`=3 and `pgm_value`=5'h15 from cycle 1, `pgm` high in cycles 2–5, and `done` in cycle 8.
- **Clear plus multi-write:** `clr_first`=1, `mask`=8'h81. Expect `clr` high in cycles 1–4, entry 0 strobed in cycles 8–11, entry 7 strobed in cycles 15–18, and `done` in cycle 21.
- **Empty request:** `mask`=0, `clr_first`=0. Expect `done` in cycle 1, and `clr`/`pgm` never rise.
- **Collisions:**
  - A `wr_en` to entry 2 in the same cycle as `start` with `mask`=8'h04: the new value appears on `pgm_value`.
  - A second `start` while busy: an `err` pulse, and the sequence is unaltered.
- **Reset mid-strobe:** assert `rst` in cycle 3 of a write. Expect `pgm`=0, `busy`=0 and all outputs 0 on the next edge; the next `start` programs entry value 0.
- **Readback (with `ADPLL_PGM_READBACK_EN`):** write entry 6=5'h1F, set `rd_addr`=6. Expect `rd_data`=5'h1F one cycle later, including during an active sequence.
